// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared state encoding and widths for the LED blink blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int FLASH_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running prescaler emitting a one-cycle tick every
//               TICK_DIV clocks; a synchronous clear restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int              c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_blink_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_arbiter
// Description : Round-robin owner of one LED; flashes a 1-15 burst for the
//               granted requester and pulses done on normal completion.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TICK_DIV  = 2_500_000,
    parameter int ON_TICKS  = 5,
    parameter int OFF_TICKS = 5,
    parameter int GAP_TICKS = 10
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req,
    input  logic [FLASH_CNT_W*N_REQ-1:0] req_cnt,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             done,
    output logic                         busy,
    output logic                         led
);

    localparam int c_PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_SUM_W  = c_PTR_W + 1;
    localparam int c_PH_MAX = (ON_TICKS > OFF_TICKS) ?
                              ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                              ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_SUM_W-1:0] c_NREQ     = c_SUM_W'(N_REQ);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(N_REQ - 1);
    localparam logic [c_PH_W-1:0]  c_ON_LAST  = c_PH_W'(ON_TICKS - 1);
    localparam logic [c_PH_W-1:0]  c_OFF_LAST = c_PH_W'(OFF_TICKS - 1);
    localparam logic [c_PH_W-1:0]  c_GAP_LAST = c_PH_W'(GAP_TICKS - 1);

    led_state_t               r_state;
    led_state_t               w_state_nxt;
    logic [N_REQ-1:0]         r_grant;
    logic [N_REQ-1:0]         r_done;
    logic                     r_busy;
    logic                     r_led;
    logic [c_PTR_W-1:0]       r_ptr;
    logic [FLASH_CNT_W-1:0]   r_flash;
    logic [c_PH_W-1:0]        r_phase;

    logic                     w_tick;
    logic                     w_clr;
    logic                     w_found;
    logic [c_PTR_W-1:0]       w_winner;
    logic [c_PTR_W-1:0]       w_ptr_nxt;
    logic [c_SUM_W-1:0]       w_sum;
    logic [N_REQ-1:0]         w_winner_oh;
    logic [FLASH_CNT_W-1:0]   w_cnt_sel;
    logic                     w_owner_req;
    logic                     w_load;
    logic                     w_off_end;
    logic                     w_finish;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // First requester at or after the pointer, wrapping at N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_SUM_W'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (!w_found && req[w_sum[c_PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_cnt_sel   = '0;
        w_winner_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == c_PTR_W'(k)) begin
                w_cnt_sel      = req_cnt[FLASH_CNT_W*k +: FLASH_CNT_W];
                w_winner_oh[k] = w_found;
            end
        end
    end

    assign w_ptr_nxt   = (w_winner == c_PTR_LAST) ? '0 : (w_winner + c_PTR_W'(1));
    assign w_owner_req = |(req & r_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_off_end   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ON;
                    w_load      = 1'b1;
                end
            end
            ST_ON: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_GAP;
                end else if (w_tick && (r_phase == c_ON_LAST)) begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_OFF: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_GAP;
                end else if (w_tick && (r_phase == c_OFF_LAST)) begin
                    w_off_end = 1'b1;
                    if (r_flash <= FLASH_CNT_W'(1)) begin
                        w_state_nxt = ST_GAP;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick && (r_phase == c_GAP_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every phase starts from a fresh prescaler period.
    assign w_clr = (w_state_nxt != r_state);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_led   <= 1'b0;
            r_ptr   <= '0;
            r_flash <= '0;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= (w_state_nxt == ST_ON);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_finish ? r_grant : '0;

            if (w_load) begin
                r_grant <= w_winner_oh;
                r_ptr   <= w_ptr_nxt;
                r_flash <= (w_cnt_sel == '0) ? FLASH_CNT_W'(1) : w_cnt_sel;
            end else begin
                if ((w_state_nxt == ST_GAP) || (w_state_nxt == ST_IDLE)) begin
                    r_grant <= '0;
                end
                if (w_off_end) begin
                    r_flash <= r_flash - FLASH_CNT_W'(1);
                end
            end

            if (w_clr) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + c_PH_W'(1);
            end
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign led   = r_led;

endmodule : led_blink_arbiter
`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blink_arbiter
// Description : Self-checking bench: vector table plus corner sequences, with
//               a burst scoreboard fed at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_arbiter;

    localparam int N_REQ     = 4;
    localparam int TICK_DIV  = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 2;
    localparam int GAP_TICKS = 3;

    localparam int c_ON_CYC   = ON_TICKS * TICK_DIV;
    localparam int c_FLASH    = (ON_TICKS + OFF_TICKS) * TICK_DIV;
    localparam int c_GAP_CYC  = GAP_TICKS * TICK_DIV;

    typedef struct {
        logic [3:0] grant;
        int         flashes;
        int         len;
        bit         abort;
    } exp_t;

    typedef struct {
        int         idx;
        logic [3:0] cnt;
        logic [3:0] exp_grant;
        int         exp_flashes;
        int         exp_len;
    } vec_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [3:0]       req;
    logic [15:0]      req_cnt;
    logic [3:0]       grant;
    logic [3:0]       done;
    logic             busy;
    logic             led;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    vec_t vecs[4];

    led_blink_arbiter #(
        .N_REQ     (N_REQ),
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .req_cnt (req_cnt),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .led     (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) timeout("wait_idle");
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (done === 4'b0000 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (done === 4'b0000) timeout("wait_done");
    endtask

    // Called on the first GAP sample; counts busy samples until IDLE.
    task automatic measure_gap(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("done_width", int'(done), 0);
        end
        chk(name, n, c_GAP_CYC);
    endtask

    task automatic run_single(input vec_t v);
        wait_idle();
        req_cnt = '0;
        req_cnt[4*v.idx +: 4] = v.cnt;
        req = '0;
        req[v.idx] = 1'b1;
        sb.push_back('{v.exp_grant, v.exp_flashes, v.exp_len, 1'b0});
        @(negedge clk);
        chk("grant_latency", int'(grant), int'(v.exp_grant));
        wait_done();
        req = '0;
        measure_gap("gap_len");
    endtask

    // Burst monitor: records each grant window and scores it on release.
    initial begin
        bit   in_burst = 1'b0;
        int   b_start = 0;
        int   b_rises = 0;
        int   b_bad = 0;
        int   k;
        logic [3:0] b_grant = '0;
        logic b_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (in_burst && grant !== b_grant) begin
                    if (sb.size() == 0) begin
                        timeout("sb_underflow");
                    end else begin
                        e = sb.pop_front();
                        chk("sb_grant", int'(b_grant), int'(e.grant));
                        chk("sb_done", int'(done), e.abort ? 0 : int'(e.grant));
                        chk("sb_flashes", b_rises, e.flashes);
                        chk("sb_len", cyc - b_start, e.len);
                        chk("sb_led_pattern", b_bad, 0);
                    end
                    in_burst = 1'b0;
                end
                if (!in_burst && grant !== 4'b0000) begin
                    in_burst = 1'b1;
                    b_start  = cyc;
                    b_grant  = grant;
                    b_rises  = 0;
                    b_bad    = 0;
                    b_prev   = 1'b0;
                end
                if (in_burst) begin
                    k = cyc - b_start;
                    if (led !== ((k % c_FLASH) < c_ON_CYC)) b_bad++;
                    if (led && !b_prev) b_rises++;
                    b_prev = led;
                end
            end
        end
    end

    initial begin
        int d_cyc;
        vecs[0] = '{1, 4'd2,  4'b0010, 2,  2 * c_FLASH};
        vecs[1] = '{0, 4'd0,  4'b0001, 1,  1 * c_FLASH};
        vecs[2] = '{3, 4'd15, 4'b1000, 15, 15 * c_FLASH};
        vecs[3] = '{2, 4'd1,  4'b0100, 1,  1 * c_FLASH};

        rstn = 1'b0;
        req = '0;
        req_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_led", int'(led), 0);
        rstn = 1'b1;
        mon_en = 1'b1;

        // Round-robin with every requester held
        req = 4'b1111;
        req_cnt = 16'h1111;
        sb.push_back('{4'b0001, 1, c_FLASH, 1'b0});
        sb.push_back('{4'b0010, 1, c_FLASH, 1'b0});
        sb.push_back('{4'b0100, 1, c_FLASH, 1'b0});
        sb.push_back('{4'b1000, 1, c_FLASH, 1'b0});
        sb.push_back('{4'b0001, 1, c_FLASH, 1'b0});
        for (int i = 0; i < 5; i++) wait_done();
        req = '0;
        measure_gap("rr_gap");

        foreach (vecs[i]) run_single(vecs[i]);

        // Abort: requester 2 drops after 5 ON cycles
        wait_idle();
        req_cnt = 16'h0300;
        req = 4'b0100;
        sb.push_back('{4'b0100, 1, 5, 1'b1});
        @(negedge clk);
        chk("abort_grant", int'(grant), 4'b0100);
        repeat (4) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("abort_led", int'(led), 0);
        chk("abort_grant_drop", int'(grant), 0);
        chk("abort_done", int'(done), 0);
        measure_gap("abort_gap");

        // Late request raised during the GAP
        wait_idle();
        req_cnt = 16'h0110;
        req = 4'b0010;
        sb.push_back('{4'b0010, 1, c_FLASH, 1'b0});
        @(negedge clk);
        chk("late_first_grant", int'(grant), 4'b0010);
        wait_done();
        d_cyc = cyc;
        req = '0;
        repeat (5) @(negedge clk);
        req = 4'b0100;
        sb.push_back('{4'b0100, 1, c_FLASH, 1'b0});
        wait_idle();
        chk("late_idle_at", cyc - d_cyc, c_GAP_CYC);
        @(negedge clk);
        chk("late_grant", int'(grant), 4'b0100);
        wait_done();
        req = '0;
        measure_gap("late_gap");

        // Reset during OFF of a 2-flash burst for requester 1
        wait_idle();
        req_cnt = 16'h0020;
        req = 4'b0010;
        sb.push_back('{4'b0010, 1, c_ON_CYC + 2, 1'b1});
        @(negedge clk);
        chk("rstb_grant", int'(grant), 4'b0010);
        repeat (c_ON_CYC + 1) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstb_grant_zero", int'(grant), 0);
        chk("rstb_done_zero", int'(done), 0);
        chk("rstb_busy_zero", int'(busy), 0);
        chk("rstb_led_zero", int'(led), 0);
        rstn = 1'b1;
        req = 4'b1001;
        req_cnt = 16'h1001;
        sb.push_back('{4'b0001, 1, c_FLASH, 1'b0});
        @(negedge clk);
        chk("post_reset_grant", int'(grant), 4'b0001);
        wait_done();
        req = '0;
        measure_gap("post_reset_gap");

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_blink_arbiter
`default_nettype wire

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares one board LED between `N_REQ` requesters. Each requester asks for a burst of 1–15 flashes. The block grants the LED round-robin, generates flash timing from an internal tick prescaler, and signals completion per requester. It sits between status sources (error, heartbeat, link, user) and the LED pin. It replaces free-running per-source blinkers that would otherwise fight over the same output.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, valid range 2–8.
- `TICK_DIV`, default 2_500_000: clocks per timing tick (50 ms at 50 MHz).
- `ON_TICKS`, default 5: ticks the LED is lit per flash.
- `OFF_TICKS`, default 5: ticks the LED is dark between flashes.
- `GAP_TICKS`, default 10: dark ticks after each burst, before the next grant.

Ports:
- `clk`, input, 1: the single clock; all logic on its rising edge.
- `rstn`, input, 1: reset, synchronous and active-low.
- `req`, input, `N_REQ`: per-requester request level.
- `req_cnt`, input, `4*N_REQ`: flash count; requester i uses bits [4i+3:4i].
- `grant`, output, `N_REQ`: one-hot owner of the LED; all zero when no burst is active.
- `done`, output, `N_REQ`: one-cycle pulse when requester i's burst completes normally.
- `busy`, output, 1: high when state is not IDLE.
- `led`, output, 1: LED drive, active-high, registered.

## Operation
- **Reset** (`rstn`=0 at a clock edge):
  - State goes to IDLE.
  - `led`, `grant`, `done`, `busy` = 0.
  - Round-robin pointer = 0; prescaler and counters = 0.
  - Reset mid-burst aborts the burst immediately, with no `done`.
- **IDLE**:
  - `led`=0.
  - If `req` is nonzero, the winner is the first set bit at or after the pointer, searching upward and wrapping.
  - Next cycle: latch `grant`, load the flash counter from `req_cnt[winner]` (value 0 is treated as 1), clear the prescaler and phase counter, enter ON.
  - Pointer becomes winner+1 mod `N_REQ`.
- **ON**: `led`=1. After `ON_TICKS` ticks, go to OFF.
- **OFF**:
  - `led`=0. After `OFF_TICKS` ticks, decrement the flash counter.
  - If the counter reaches 0, go to GAP and pulse `done[owner]`; otherwise go to ON.
- **GAP**:
  - `led`=0, `grant`=0.
  - After `GAP_TICKS` ticks, go to IDLE.
- **Abort**: if `req[owner]` falls during ON or OFF, go to GAP on the next edge with `led`=0 and no `done`. The pointer is still advanced.
- **Request handshake**:
  - `req` is a level. It is sampled only in IDLE.
  - `req_cnt` is sampled only at the grant edge.
  - A requester still holding `req` after `done` is treated as a new request and competes normally.
- **Simultaneous requests**: resolved only by the round-robin pointer. Requests arriving during a burst wait; none are lost while held.
- **Widths**:
  - Prescaler is `$clog2(TICK_DIV)` bits and wraps at `TICK_DIV-1`.
  - Phase counter is sized for `max(ON,OFF,GAP)_TICKS`.
  - Flash counter is 4 bits.

## Timing
- Tick: a one-cycle pulse when the prescaler wraps.
  - The prescaler clears on the grant edge and on every state change.
  - Each phase therefore lasts exactly ticks×`TICK_DIV` cycles.
- Grant latency:
  - `req` high in IDLE at edge t gives `grant`, `busy` and `led`=1 at edge t+1.
  - A request arriving in the GAP waits until IDLE, then is granted one cycle later.
- Burst of K flashes, from grant to `done`: K×(`ON_TICKS`+`OFF_TICKS`)×`TICK_DIV` cycles.
- Transition to GAP: `done` and the `grant` drop occur on the same edge as the GAP entry.
- GAP: lasts `GAP_TICKS`×`TICK_DIV` cycles; then `busy`=0 for at least one IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `led_pkg` holds:
  - the state encoding (IDLE, ON, OFF, GAP, 2 bits);
  - the flash-count width constant (4).
- Sub-module `led_tick_gen`: prescaler with synchronous clear input and `tick` output, parameterised by `TICK_DIV`. It is reusable by other LED blocks.
- The top level holds the arbiter, the FSM and the counters.

## Test plan
Bench parameters: `TICK_DIV`=4, `ON_TICKS`=2, `OFF_TICKS`=2, `GAP_TICKS`=3, `N_REQ`=4.
1. **Single burst**:
   - Stimulus: `req[1]`=1 with `req_cnt[1]`=2.
   - Expect: `grant`=0010 next cycle; `led` pattern high 8 / low 8 / high 8 / low 8 cycles.
   - Expect: `done[1]` pulse at cycle 32 after grant; `busy` low 12 cycles later.
2. **Round-robin**:
   - Stimulus: `req`=1111 held, all counts 1.
   - Expect: grants in order 0001, 0010, 0100, 1000, 0001, each burst 16 cycles long.
3. **Count zero**: `req_cnt`=0 gives exactly one flash and a `done` pulse.
4. **Abort**:
   - Stimulus: `req[2]` dropped after 5 cycles of ON.
   - Expect: `led`=0 next cycle, no `done[2]`, GAP of 12 cycles, then IDLE.
5. **Reset mid-burst**:
   - Stimulus: `rstn`=0 for 1 cycle during OFF.
   - Expect: all outputs 0 after that edge; pointer 0; next grant goes to the lowest requesting index.
6. **Late request**: a request raised during the GAP is granted exactly 1 cycle after IDLE is entered.
